// File: rtl/bsdec_pkg.sv
// Shared types and constants for the rate-coded bitstream decoder.
package bsdec_pkg;
  localparam int WORD_W    = 32;
  localparam int FRAC_BITS = 10;
  localparam logic [15:0] ONE_Q = 16'h0400;

  typedef logic [15:0] fix16_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} bsdec_state_t;

  // Window sum -> Q6.10: one ones-count step is 2**(FRAC_BITS-log2(WORD_W)) LSB,
  // then divide by the window length. Truncates.
  function automatic fix16_t bsdec_decode(input logic [13:0] acc, input int log2_win);
    logic [19:0] t;
    t = ({6'b0, acc} << (FRAC_BITS - $clog2(WORD_W))) >> log2_win;
    return t[15:0];
  endfunction
endpackage

// File: rtl/bitstream_decoder_if.sv
// Word stream in, decoded value out. sat_cnt exists only with BSDEC_SAT_FLAG_EN.
interface bitstream_decoder_if;
  import bsdec_pkg::*;

  logic [WORD_W-1:0] bs_in;
  logic              bs_valid;
  logic              clear;
  fix16_t            y_out;
  logic              y_valid;
  logic              busy;
`ifdef BSDEC_SAT_FLAG_EN
  logic [15:0]       sat_cnt;
`endif

  modport master (
    output bs_in, bs_valid, clear,
    input  y_out, y_valid, busy
`ifdef BSDEC_SAT_FLAG_EN
    , input sat_cnt
`endif
  );

  modport slave (
    input  bs_in, bs_valid, clear,
    output y_out, y_valid, busy
`ifdef BSDEC_SAT_FLAG_EN
    , output sat_cnt
`endif
  );
endinterface

// File: rtl/bitstream_decoder_popcount.sv
// Combinational ones-count of a 32-bit word as a balanced adder tree.
module popcount32 (
  input  logic [31:0] word,
  output logic [5:0]  count
);
  logic [1:0] s1 [16];
  logic [2:0] s2 [8];
  logic [3:0] s3 [4];
  logic [4:0] s4 [2];

  always_comb begin
    for (int i = 0; i < 16; i++) s1[i] = {1'b0, word[2*i]} + {1'b0, word[2*i+1]};
    for (int i = 0; i < 8; i++)  s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
    for (int i = 0; i < 4; i++)  s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
    for (int i = 0; i < 2; i++)  s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
    count = {1'b0, s4[0]} + {1'b0, s4[1]};
  end
endmodule

// File: rtl/bitstream_decoder.sv
// Averages ones-counts over 2**LOG2_WIN accepted words and rebuilds a Q6.10 value.
// Optional clipping counter: define BSDEC_SAT_FLAG_EN.
module bitstream_decoder
  import bsdec_pkg::*;
#(
  parameter int LOG2_WIN = 2
) (
  input  logic clk,
  input  logic reset,
  bitstream_decoder_if.slave bus
);
  localparam int ACC_W = 6 + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2**LOG2_WIN - 1);

  bsdec_state_t     state;
  logic [5:0]       pc_w, pc_q;
  logic             pc_v;
  logic [ACC_W-1:0] acc, dump_acc, sum;
  logic [CNT_W-1:0] wcnt;
  fix16_t           y_q;
  logic             yv_q;

  popcount32 u_popcount (.word(bus.bs_in), .count(pc_w));

  assign sum = acc + ACC_W'(pc_q);

  // The window sum is parked in dump_acc so the accumulator can take the
  // next window's first word during the DUMP cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      pc_v     <= 1'b0;
      acc      <= '0;
      dump_acc <= '0;
      wcnt     <= '0;
      y_q      <= '0;
      yv_q     <= 1'b0;
    end else begin
      yv_q <= 1'b0;
      pc_q <= pc_w;
      pc_v <= bus.bs_valid & ~bus.clear;
      if (state == DUMP) begin
        y_q  <= bsdec_decode(14'(dump_acc), LOG2_WIN);
        yv_q <= 1'b1;
      end
      if (bus.clear) begin
        acc   <= '0;
        wcnt  <= '0;
        state <= IDLE;
      end else if (pc_v) begin
        if (wcnt == LAST) begin
          dump_acc <= sum;
          acc      <= '0;
          wcnt     <= '0;
          state    <= DUMP;
        end else begin
          acc   <= sum;
          wcnt  <= wcnt + CNT_W'(1);
          state <= ACCUM;
        end
      end else if (state == DUMP) begin
        state <= IDLE;
      end
    end
  end

  assign bus.y_out   = y_q;
  assign bus.y_valid = yv_q;
  assign bus.busy    = (state == ACCUM) | pc_v;

`ifdef BSDEC_SAT_FLAG_EN
  logic        clip_q, win_sat, dump_sat;
  logic [15:0] sat_q;

  // The clip flag travels alongside pc_q and follows the same window bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clip_q   <= 1'b0;
      win_sat  <= 1'b0;
      dump_sat <= 1'b0;
      sat_q    <= '0;
    end else begin
      clip_q <= (bus.bs_in == '0) | (bus.bs_in == '1);
      if (state == DUMP && dump_sat && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
      if (bus.clear) begin
        win_sat <= 1'b0;
      end else if (pc_v) begin
        if (wcnt == LAST) begin
          dump_sat <= win_sat | clip_q;
          win_sat  <= 1'b0;
        end else begin
          win_sat <= win_sat | clip_q;
        end
      end
    end
  end

  assign bus.sat_cnt = sat_q;
`endif
endmodule

// File: tb/tb_bitstream_decoder.sv
// Drives a 4-word-window and a 1-word-window decoder with the same stream and
// checks both against a window-averaging model every cycle, plus literal cases.
module tb_bitstream_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bs_in = '0;
  logic        bs_valid = 1'b0;
  logic        clr = 1'b0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int edge_n = 0;

  always #5 clk = ~clk;

  bitstream_decoder_if if_w4 ();
  bitstream_decoder_if if_w1 ();
  assign if_w4.bs_in = bs_in;  assign if_w4.bs_valid = bs_valid;  assign if_w4.clear = clr;
  assign if_w1.bs_in = bs_in;  assign if_w1.bs_valid = bs_valid;  assign if_w1.clear = clr;

  bitstream_decoder #(.LOG2_WIN(2)) u_w4 (.clk(clk), .reset(rst_n), .bus(if_w4));
  bitstream_decoder #(.LOG2_WIN(0)) u_w1 (.clk(clk), .reset(rst_n), .bus(if_w1));

  logic [15:0] d_y [2];
  logic        d_v [2];
  logic        d_b [2];
  assign d_y[0] = if_w4.y_out;  assign d_v[0] = if_w4.y_valid;  assign d_b[0] = if_w4.busy;
  assign d_y[1] = if_w1.y_out;  assign d_v[1] = if_w1.y_valid;  assign d_b[1] = if_w1.busy;
`ifdef BSDEC_SAT_FLAG_EN
  logic [15:0] d_s [2];
  assign d_s[0] = if_w4.sat_cnt;  assign d_s[1] = if_w1.sat_cnt;
`endif

  // Model: words collect into a window; a full window emits its average two
  // edges after the edge that accepted its last word, unless cleared first.
  int NW [2] = '{4, 1};
  int m_cnt [2], m_sum [2];
  bit m_clip [2];
  bit s_v [2][2];
  int s_y [2][2];
  bit s_c [2][2];
  int exp_y [2], exp_sat [2];
  bit exp_v [2], exp_busy [2];

  int pulses [2], last_y [2], last_t [2], prev_t [2];

  task automatic model_step();
    bit acc_now;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0; m_sum[k] = 0; m_clip[k] = 0;
        s_v[k][0] = 0; s_v[k][1] = 0;
        exp_y[k] = 0; exp_v[k] = 0; exp_busy[k] = 0; exp_sat[k] = 0;
      end else begin
        exp_v[k] = s_v[k][0];
        if (s_v[k][0]) begin
          exp_y[k] = s_y[k][0];
          if (s_c[k][0] && exp_sat[k] < 65535) exp_sat[k]++;
        end
        s_v[k][0] = s_v[k][1]; s_y[k][0] = s_y[k][1]; s_c[k][0] = s_c[k][1];
        s_v[k][1] = 0;
        acc_now = bs_valid && !clr;
        if (clr) begin
          m_cnt[k] = 0; m_sum[k] = 0; m_clip[k] = 0;
          s_v[k][0] = 0;
        end
        if (acc_now) begin
          m_sum[k] += $countones(bs_in);
          m_clip[k] |= (bs_in == 32'h0) || (bs_in == 32'hFFFFFFFF);
          m_cnt[k]++;
          if (m_cnt[k] == NW[k]) begin
            s_v[k][1] = 1; s_y[k][1] = m_sum[k] * 32 / NW[k]; s_c[k][1] = m_clip[k];
            m_cnt[k] = 0; m_sum[k] = 0; m_clip[k] = 0;
          end
        end
        exp_busy[k] = acc_now || (m_cnt[k] > 0);
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] @edge %0d: got %0h, expected %0h", name, k, edge_n, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk("y_valid", k, {31'b0, d_v[k]}, {31'b0, exp_v[k]});
      chk("y_out", k, {16'b0, d_y[k]}, exp_y[k]);
      chk("busy", k, {31'b0, d_b[k]}, {31'b0, exp_busy[k]});
`ifdef BSDEC_SAT_FLAG_EN
      chk("sat_cnt", k, {16'b0, d_s[k]}, exp_sat[k]);
`endif
      if (d_v[k] === 1'b1) begin
        pulses[k]++; last_y[k] = d_y[k]; prev_t[k] = last_t[k]; last_t[k] = edge_n;
      end
    end
  endtask

  // One clock: check outputs away from the edge, drive, then advance the model.
  task automatic cyc(input logic r, input logic [31:0] w, input logic v, input logic c);
    @(negedge clk);
    if (chk_en) compare_all();
    rst_n = r; bs_in = w; bs_valid = v; clr = c;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int p0, p1, w4e;
    // 1: reset held while words are driven
    cyc(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(1);
    chk("rst_y_out", 0, {16'b0, d_y[0]}, 32'h0);
    chk("rst_busy", 0, {31'b0, d_b[0]}, 32'h0);
    idle(2);

    // 2: full-scale window, pulse on the second edge after the accepting edge
    p0 = pulses[0];
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    w4e = edge_n;
    idle(5);
    chk("t2_pulses", 0, pulses[0] - p0, 1);
    chk("t2_y", 0, last_y[0], 32'h0400);
    chk("t2_lat", 0, last_t[0] - w4e, 2);
    chk("t2_model", 0, exp_y[0], 32'h0400);

    // 3: half-ones words with gaps
    p0 = pulses[0];
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h0000FFFF, 1'b1, 1'b0);
      idle(1);
    end
    idle(4);
    chk("t3_pulses", 0, pulses[0] - p0, 1);
    chk("t3_y", 0, last_y[0], 32'h0200);

    // 4: alternating 4/8 ones, two back-to-back windows
    p0 = pulses[0];
    for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2 == 0) ? 32'hF : 32'hFF, 1'b1, 1'b0);
    idle(5);
    chk("t4_pulses", 0, pulses[0] - p0, 2);
    chk("t4_y", 0, last_y[0], 32'h00C0);
    chk("t4_gap", 0, last_t[0] - prev_t[0], 4);

    // 5a: partial window dropped by clear
    p0 = pulses[0];
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF, 1'b1, 1'b0);
    idle(5);
    chk("t5c_pulses", 0, pulses[0] - p0, 1);
    chk("t5c_y", 0, last_y[0], 32'h0080);

    // 5b: same with reset
    p0 = pulses[0];
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cyc(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF, 1'b1, 1'b0);
    idle(5);
    chk("t5r_pulses", 0, pulses[0] - p0, 1);
    chk("t5r_y", 0, last_y[0], 32'h0080);

    // 6: single-word windows, one pulse per word
    p1 = pulses[1];
    cyc(1'b1, 32'h1, 1'b1, 1'b0);
    cyc(1'b1, 32'h3, 1'b1, 1'b0);
    cyc(1'b1, 32'h7, 1'b1, 1'b0);
    idle(4);
    chk("t6_pulses", 1, pulses[1] - p1, 3);
    chk("t6_y", 1, last_y[1], 32'h0060);
    chk("t6_gap", 1, last_t[1] - prev_t[1], 1);
`ifdef BSDEC_SAT_FLAG_EN
    cyc(1'b1, 32'h0, 1'b1, 1'b0);
    idle(4);
    chk("t6_sat", 1, {16'b0, d_s[1]}, 32'd1);
`endif

    // clear in the DUMP cycle: dump completes, the word offered with it is dropped
    p0 = pulses[0];
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF, 1'b1, 1'b0);
    idle(5);
    chk("dumpclr_pulses", 0, pulses[0] - p0, 2);
    chk("dumpclr_y", 0, last_y[0], 32'h0080);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: w = 32'h0;
        2: w = 32'hFFFFFFFF;
        default: w = $urandom & 32'h000000FF;
      endcase
      cyc($urandom_range(0, 199) != 0, w, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end
    idle(4);
    @(negedge clk);
    compare_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
